regfile_param: RTL and testbench

Parametrised multi-read-port register file. It is the next-generation replacement for the fixed 32x32 two-read-port register file in the datapath.
- Register 0 optionally hardwired to zero.
- Per-register scoreboard (busy bits) for pending-writeback tracking.
- Handshaked serial dump engine replaces the simulation-only register print.
- Sits between decode (read/reserve) and writeback (write).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_dump_fsm.sv | 97 +++++++++
 rtl/regfile_param.sv | 106 ++++++++++
 tb/tb_regfile_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Dump engine state encoding and flat-port slicing helper live here.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

    // Low bit of port `port` inside a flat bus of `width`-bit lanes.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Serial dump engine: walks every register once, one beat per valid/ready handshake.
// Reads the array through a dedicated request/response port owned by the top.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] rd_req_addr_c,
    input  logic [DATA_W-1:0] rd_resp_data,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_active,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    // Address of the beat that would be loaded on this edge; kept apart from
    // the next-state block so the read response never loops back into it.
    always_comb begin
        rd_req_addr_c = '0;
        if (state_q == DUMP_SEND) begin
            rd_req_addr_c = idx_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= DUMP_IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_SEND;
                    idx_d   = '0;
                    data_d  = rd_resp_data;
                    valid_d = 1'b1;
                end
            end
            DUMP_SEND: begin
                if (valid_q && dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DUMP_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + ADDR_W'(1);
                        data_d = rd_resp_data;
                    end
                end
            end
            DUMP_DONE: state_d = DUMP_IDLE;
            default:   state_d = DUMP_IDLE;
        endcase
        active_d = (state_d != DUMP_IDLE);
    end

    assign dump_valid  = valid_q;
    assign dump_addr   = idx_q;
    assign dump_data   = data_q;
    assign dump_active = active_q;
    assign dump_done   = done_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with busy scoreboard and serial dump.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     dump_start,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_active,
    output logic                     dump_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W-1:0] dump_rd_addr_c;
    logic [DATA_W-1:0] dump_rd_data_c;

    // Read value for one address: stored word, optional forwarding, zero register.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] v;
        v = stored;
`ifdef REGFILE_BYPASS_EN
        if (we && (wa == a)) v = wd;
`else
        if (we && (wa == a) && 1'b0) v = wd;
`endif
        if (ZR && (a == '0)) v = '0;
        return v;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_en && !(ZR && (wr_addr == '0))) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Writeback clears, reserve sets; the reserve wins on a same-address collision.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)  busy_d[wr_addr]  = 1'b0;
        if (rsv_en) busy_d[rsv_addr] = 1'b1;
        if (ZR)     busy_d[0]        = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
        assign rd_data[slice_lo(k, DATA_W) +: DATA_W] =
            read_sel(addr, mem_q[addr], wr_en, wr_addr, wr_data);
        assign rd_busy[k] = busy_q[addr];
    end

    assign dump_rd_data_c = read_sel(dump_rd_addr_c, mem_q[dump_rd_addr_c],
                                     wr_en, wr_addr, wr_data);

    regfile_dump_fsm #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clock         (clock),
        .reset_n       (reset_n),
        .dump_start    (dump_start),
        .dump_ready    (dump_ready),
        .rd_req_addr_c (dump_rd_addr_c),
        .rd_resp_data  (dump_rd_data_c),
        .dump_valid    (dump_valid),
        .dump_addr     (dump_addr),
        .dump_data     (dump_data),
        .dump_active   (dump_active),
        .dump_done     (dump_done)
    );

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: array/queue-level reference model compared
// every negedge, plus directed literal checks for writes, scoreboard, reset and dumps.
module tb_regfile_param;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 32;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              dump_start;
    logic              dump_valid;
    logic              dump_ready;
    logic [AW-1:0]     dump_addr;
    logic [DW-1:0]     dump_data;
    logic              dump_active;
    logic              dump_done;

    always #5 clock = ~clock;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_active(dump_active), .dump_done(dump_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else             n_pass++;
    endtask

    // Reference model: plain arrays plus a beat counter for the dump walk.
    logic [DW-1:0]    m_mem [DEPTH];
    logic [DEPTH-1:0] m_busy;
    bit               m_active, m_valid, m_done;
    int               m_idx;
    logic [DW-1:0]    m_data;

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_mem[a];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
            m_busy = '0; m_active = 0; m_valid = 0; m_done = 0; m_idx = 0; m_data = '0;
        end else begin
            if (!m_active) begin
                if (dump_start) begin
                    m_active = 1; m_valid = 1; m_idx = 0; m_data = mread('0);
                end
            end else if (m_done) begin
                m_done = 0; m_active = 0;
            end else if (dump_ready) begin
                if (m_idx == int'(DEPTH) - 1) begin
                    m_valid = 0; m_done = 1;
                end else begin
                    m_idx++; m_data = mread(AW'(m_idx));
                end
            end
            if (wr_en && wr_addr != '0) m_mem[wr_addr] = wr_data;
            if (wr_en)  m_busy[wr_addr]  = 1'b0;
            if (rsv_en) m_busy[rsv_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
    end

    int            cyc = 0;
    int            beats, dones, last_beat_cyc, done_cyc;
    logic [DW-1:0] beat_data [DEPTH];

    always @(negedge clock) begin
        cyc++;
        for (int k = 0; k < int'(NR); k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            chk("rd_data", 64'(rd_data[k*DW +: DW]), 64'(mread(a)));
            chk("rd_busy", 64'(rd_busy[k]), 64'(m_busy[a]));
        end
        chk("dump_valid", 64'(dump_valid), 64'(m_valid));
        chk("dump_active", 64'(dump_active), 64'(m_active));
        chk("dump_done", 64'(dump_done), 64'(m_done));
        if (m_valid) begin
            chk("dump_addr", 64'(dump_addr), 64'(m_idx));
            chk("dump_data", 64'(dump_data), 64'(m_data));
        end
        if (dump_valid && dump_ready) begin
            beats++;
            beat_data[dump_addr] = dump_data;
            if (dump_addr == AW'(DEPTH - 1)) last_beat_cyc = cyc;
        end
        if (dump_done) begin
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_dump_stats();
        beats = 0; dones = 0; last_beat_cyc = 0; done_cyc = 0;
        for (int i = 0; i < int'(DEPTH); i++) beat_data[i] = '0;
    endtask

    initial begin
        bit wrote, restarted;
        reset_n = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rsv_en = 0; rsv_addr = '0; dump_start = 0; dump_ready = 0;
        clr_dump_stats();
        #1 reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_rd", 64'(rd_data), 64'(0));

        // Plain write and zero-register write.
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; tick();
        wr_addr = 5'd0; tick();
        wr_en = 0; rd_addr = {5'd0, 5'd5}; #1;
        chk("r5_port0", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
        chk("r0_port1", 64'(rd_data[63:32]), 64'(0));
        rd_addr = {5'd0, 5'd0}; #1;
        chk("r0_both", 64'(rd_data), 64'(0));
        tick();

        // Same-cycle write/read of r7.
        rd_addr = {5'd7, 5'd7}; wr_en = 1; wr_addr = 5'd7; wr_data = 32'h1234; #1;
`ifdef REGFILE_BYPASS_EN
        chk("r7_same_cycle", 64'(rd_data[31:0]), 64'h1234);
`else
        chk("r7_same_cycle", 64'(rd_data[31:0]), 64'(0));
`endif
        tick();
        wr_en = 0; #1;
        chk("r7_next_cycle", 64'(rd_data[63:32]), 64'h1234);

        // Scoreboard.
        rd_addr = {5'd0, 5'd9};
        rsv_en = 1; rsv_addr = 5'd9; tick();
        rsv_en = 0; #1;
        chk("busy_after_rsv", 64'(rd_busy[0]), 64'(1));
        wr_en = 1; wr_addr = 5'd9; wr_data = 32'h99; tick();
        wr_en = 0; #1;
        chk("busy_after_wr", 64'(rd_busy[0]), 64'(0));
        wr_en = 1; rsv_en = 1; tick();
        wr_en = 0; rsv_en = 0; #1;
        chk("busy_rsv_wins", 64'(rd_busy[0]), 64'(1));
        rsv_en = 1; rsv_addr = 5'd0; tick();
        rsv_en = 0; #1;
        chk("busy_r0", 64'(rd_busy[1]), 64'(0));

        // Asynchronous reset in the middle of a dump.
        clr_dump_stats();
        rd_addr = {5'd9, 5'd5}; dump_ready = 1; dump_start = 1; tick();
        dump_start = 0; tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_rd_busy", 64'(rd_busy), 64'(0));
        chk("rst_dump_valid", 64'(dump_valid), 64'(0));
        chk("rst_dump_active", 64'(dump_active), 64'(0));
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("abort_no_done", 64'(dones), 64'(0));

        // Preload value = index*3 and dump with dump_ready held high.
        dump_ready = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i * 3); tick();
        end
        wr_en = 0;
        clr_dump_stats();
        dump_ready = 1; dump_start = 1; tick();
        dump_start = 0;
        for (int c = 0; c < 100 && dones == 0; c++) tick();
        tick(); tick();
        chk("dump1_done_cnt", 64'(dones), 64'(1));
        chk("dump1_beats", 64'(beats), 64'(32));
        chk("dump1_done_gap", 64'(done_cyc - last_beat_cyc), 64'(1));
        for (int i = 0; i < int'(DEPTH); i++) chk("dump1_beat", 64'(beat_data[i]), 64'(i * 3));

        // Stalling dump with a mid-dump write and an ignored restart.
        clr_dump_stats();
        wrote = 0; restarted = 0;
        dump_ready = 0; dump_start = 1; tick();
        dump_start = 0;
        for (int c = 0; c < 200 && dones == 0; c++) begin
            dump_ready = (c % 2 == 0);
            wr_en = 0; dump_start = 0;
            if (!wrote && beats >= 10) begin
                wr_en = 1; wr_addr = 5'd20; wr_data = 32'hAA; wrote = 1;
            end
            if (!restarted && beats == 5) begin
                dump_start = 1; restarted = 1;
            end
            tick();
        end
        wr_en = 0; dump_start = 0; dump_ready = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("dump2_done_cnt", 64'(dones), 64'(1));
        chk("dump2_beats", 64'(beats), 64'(32));
        chk("dump2_beat20", 64'(beat_data[20]), 64'hAA);
        chk("dump2_beat19", 64'(beat_data[19]), 64'(57));
        chk("dump2_beat21", 64'(beat_data[21]), 64'(63));
        chk("dump2_idle", 64'(dump_active), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
